// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search engine.
package sar_pkg;

    localparam int SAR_WIDTH_DEFAULT = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        PROBE = 1'b1
    } sar_state_e;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_PROBE = 1'b1;

    function automatic logic cmp_one_hot(input logic lower, input logic equal, input logic greater);
        return ({lower, equal, greater} == 3'b100) ||
               ({lower, equal, greater} == 3'b010) ||
               ({lower, equal, greater} == 3'b001);
    endfunction

endpackage

// File: rtl/sar_search.sv
// SAR search engine: drives trial values into an external comparator, one bit per cycle MSB first.
// Optional build macro SAR_EARLY_EXIT_EN ends the search on the first equal response.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; trial holds the last driven value
// ST_PROBE | trial = acc | (1<<k) presented, comparator sampled at cycle end
module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    output logic [WIDTH-1:0] trial_o,
    input  logic             cmp_lower_i,
    input  logic             cmp_equal_i,
    input  logic             cmp_greater_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             err_o
);

    localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [0:0]       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             one_hot;
    logic             stop_early;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        one_hot  = cmp_one_hot(cmp_lower_i, cmp_equal_i, cmp_greater_i);
        bit_mask = {{(WIDTH-1){1'b0}}, 1'b1} << k_q;
        // A malformed response is treated as "lower": the bit stays cleared.
        acc_next = (one_hot && (cmp_greater_i || cmp_equal_i)) ? (acc_q | bit_mask) : acc_q;
`ifdef SAR_EARLY_EXIT_EN
        stop_early = one_hot && cmp_equal_i;
`else
        stop_early = 1'b0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        acc_d    = acc_q;
        trial_d  = trial_q;
        result_d = result_q;
        done_d   = 1'b0;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_PROBE;
                    k_d     = KW'(WIDTH - 1);
                    acc_d   = '0;
                    trial_d = {1'b1, {(WIDTH-1){1'b0}}};
                    err_d   = 1'b0;
                end
            end
            ST_PROBE: begin
                acc_d = acc_next;
                if (!one_hot) begin
                    err_d = 1'b1;
                end
                if ((k_q == '0) || stop_early) begin
                    result_d = acc_next;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    k_d     = k_q - 1'b1;
                    trial_d = acc_next | ({{(WIDTH-1){1'b0}}, 1'b1} << (k_q - 1'b1));
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            acc_q    <= '0;
            trial_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign trial_o  = trial_q;
    assign busy_o   = (state_q == ST_PROBE);
    assign done_o   = done_q;
    assign result_o = result_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search with a behavioural magnitude comparator as responder.
module tb_sar_search;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] trial;
    logic       cmp_l, cmp_e, cmp_g;
    logic       busy, done, err;
    logic [3:0] result;

    logic [3:0] target;
    logic       ovr;

    int checks;
    int errors;

    logic [3:0] obs_trial [0:15];
    int         obs_lat;
    logic [3:0] obs_res;
    logic       obs_err;
    logic       obs_to;

    sar_search #(.WIDTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .trial_o       (trial),
        .cmp_lower_i   (cmp_l),
        .cmp_equal_i   (cmp_e),
        .cmp_greater_i (cmp_g),
        .busy_o        (busy),
        .done_o        (done),
        .result_o      (result),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        cmp_l = (target < trial);
        cmp_e = (target == trial);
        cmp_g = (target > trial);
        if (ovr) begin
            cmp_l = 1'b0;
            cmp_e = 1'b0;
            cmp_g = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one search from an idle engine and records what was observed.
    task automatic run_search(input logic [3:0] tgt, input int fault_probe);
        target  = tgt;
        ovr     = 1'b0;
        obs_to  = 1'b1;
        obs_lat = 0;
        obs_res = '0;
        obs_err = 1'b0;
        for (int i = 0; i < 16; i++) obs_trial[i] = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 1; cyc < 16; cyc++) begin
            if (busy) begin
                obs_trial[cyc] = trial;
                ovr = (cyc == fault_probe);
            end
            if (done) begin
                obs_lat = cyc;
                obs_res = result;
                obs_err = err;
                obs_to  = 1'b0;
                break;
            end
            step();
        end
        ovr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        target = '0;
        ovr = 1'b0;
        step();
        step();
        checks++;
        if ({trial, busy, done, result, err} !== 11'd0) begin
            errors++;
            $display("FAIL reset_values got trial=%0d busy=%0b done=%0b result=%0d err=%0b want all 0",
                     trial, busy, done, result, err);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_full_search();
        logic [3:0] exp_tr [0:3];
        exp_tr[0] = 4'd8; exp_tr[1] = 4'd12; exp_tr[2] = 4'd10; exp_tr[3] = 4'd9;
        run_search(4'd9, 0);
        checks++;
        if (obs_to !== 1'b0) begin
            errors++;
            $display("FAIL full9_timeout no done within bound");
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_trial[i+1] !== exp_tr[i]) begin
                errors++;
                $display("FAIL full9_trial cycle %0d got %0d want %0d", i + 1, obs_trial[i+1], exp_tr[i]);
            end
        end
        checks++;
        if (obs_lat !== 5 || obs_res !== 4'd9 || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL full9_result got lat=%0d res=%0d err=%0b want lat=5 res=9 err=0",
                     obs_lat, obs_res, obs_err);
        end
    endtask

    task automatic test_early_exit();
        int exp8, exp12;
`ifdef SAR_EARLY_EXIT_EN
        exp8  = 2;
        exp12 = 3;
`else
        exp8  = 5;
        exp12 = 5;
`endif
        run_search(4'd8, 0);
        checks++;
        if (obs_trial[1] !== 4'd8 || obs_lat !== exp8 || obs_res !== 4'd8) begin
            errors++;
            $display("FAIL early8 got trial1=%0d lat=%0d res=%0d want trial1=8 lat=%0d res=8",
                     obs_trial[1], obs_lat, obs_res, exp8);
        end
        run_search(4'd12, 0);
        checks++;
        if (obs_lat !== exp12 || obs_res !== 4'd12) begin
            errors++;
            $display("FAIL early12 got lat=%0d res=%0d want lat=%0d res=12", obs_lat, obs_res, exp12);
        end
    endtask

    task automatic test_boundaries();
        run_search(4'd0, 0);
        checks++;
        if (obs_lat !== 5 || obs_res !== 4'd0 || obs_trial[4] !== 4'd1) begin
            errors++;
            $display("FAIL bound0 got lat=%0d res=%0d trial4=%0d want lat=5 res=0 trial4=1",
                     obs_lat, obs_res, obs_trial[4]);
        end
        run_search(4'd15, 0);
        checks++;
        if (obs_lat !== 5 || obs_res !== 4'd15 || obs_trial[3] !== 4'd14) begin
            errors++;
            $display("FAIL bound15 got lat=%0d res=%0d trial3=%0d want lat=5 res=15 trial3=14",
                     obs_lat, obs_res, obs_trial[3]);
        end
    endtask

    task automatic test_fault();
        bit seen;
        run_search(4'd9, 3);
        checks++;
        if (obs_res !== 4'd9 || obs_err !== 1'b1 || obs_lat !== 5) begin
            errors++;
            $display("FAIL fault9 got res=%0d err=%0b lat=%0d want res=9 err=1 lat=5", obs_res, obs_err, obs_lat);
        end
        step();
        step();
        step();
        checks++;
        if (err !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL fault_sticky got err=%0b done=%0b want err=1 done=0", err, done);
        end
        run_search(4'd11, 3);
        checks++;
        if (obs_res !== 4'd9 || obs_err !== 1'b1) begin
            errors++;
            $display("FAIL fault11 got res=%0d err=%0b want res=9 err=1", obs_res, obs_err);
        end
        target = 4'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL fault_clear got err=%0b busy=%0b want err=0 busy=1", err, busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen || result !== 4'd9) begin
            errors++;
            $display("FAIL fault_recover got done_seen=%0b result=%0d want 1 and 9", seen, result);
        end
    endtask

    task automatic test_back_to_back();
        logic       b [0:12];
        logic       d [0:12];
        logic [3:0] t [0:12];
        bit         idle;
        target = 4'd9;
        start = 1'b1;
        step();
        for (int c = 1; c <= 12; c++) begin
            b[c] = busy;
            d[c] = done;
            t[c] = trial;
            step();
        end
        start = 1'b0;
        checks++;
        if (t[1] !== 4'd8 || t[2] !== 4'd12 || t[4] !== 4'd9 || b[4] !== 1'b1 || d[4] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first got t1=%0d t2=%0d t4=%0d b4=%0b d4=%0b want 8 12 9 1 0",
                     t[1], t[2], t[4], b[4], d[4]);
        end
        checks++;
        if (d[5] !== 1'b1 || b[5] !== 1'b0 || b[6] !== 1'b1 || t[6] !== 4'd8) begin
            errors++;
            $display("FAIL b2b_restart got d5=%0b b5=%0b b6=%0b t6=%0d want 1 0 1 8", d[5], b[5], b[6], t[6]);
        end
        checks++;
        if (d[10] !== 1'b1 || t[7] !== 4'd12 || b[11] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second got d10=%0b t7=%0d b11=%0b want 1 12 1", d[10], t[7], b[11]);
        end
        idle = 1'b0;
        for (int i = 0; i < 10 && !idle; i++) begin
            if (!busy) idle = 1'b1;
            else step();
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL b2b_drain busy still %0b want 0", busy);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int n_done;
        target = 4'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (trial !== 4'd12 || busy !== 1'b1 || result !== 4'd9) begin
            errors++;
            $display("FAIL rstmid_pre got trial=%0d busy=%0b result=%0d want 12 1 9", trial, busy, result);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({trial, busy, done, result, err} !== 11'd0) begin
            errors++;
            $display("FAIL rstmid_clear got trial=%0d busy=%0b done=%0b result=%0d err=%0b want all 0",
                     trial, busy, done, result, err);
        end
        step();
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done || busy) n_done++;
        end
        checks++;
        if (n_done !== 0) begin
            errors++;
            $display("FAIL rstmid_nodone got %0d done/busy cycles want 0", n_done);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_full_search();
        test_early_exit();
        test_boundaries();
        test_fault();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
